dense_layer_seq: RTL
====================

// Module: dense_layer_seq
// PURPOSE
//  Generic sequential fully-connected layer: out[j] = act(sum_i in[i]*W[j][i] + b[j]).
//  Computes LANES neurons per pass against an external synchronous weight/bias ROM.
//  Buffers all N_OUT activated results for random read-out.
//  Serves as the reusable engine for layer 1 (64->48, sign) and later layers.
// PARAMETERS
//  N_IN      64  inputs per neuron
//  N_OUT     48  neurons; N_OUT % LANES == 0
//  LANES     1   neurons computed in parallel per pass
//  IN_W      2   signed input width
//  W_W       2   signed weight width
//  B_W       4   signed bias width
//  ACC_W     12  signed accumulator width
//  OUT_W     2   signed output width
//  ACT_MODE  0   activation: 0 = sign, 1 = ReLU, 2 = identity
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 async active-low reset
//  start      in   1                 start request, sampled in IDLE/DONE
//  abort      in   1                 cancel run, return to IDLE
//  in_flat    in   N_IN*IN_W         inputs; in[i] = in_flat[i*IN_W +: IN_W]
//  wrom_addr  out  clog2(N_IN*N_OUT/LANES)  weight row address = grp*N_IN+idx
//  wrom_data  in   LANES*W_W         lane l weight at [l*W_W +: W_W]; 1-cycle latency
//  brom_addr  out  clog2(N_OUT/LANES)       bias address = grp
//  brom_data  in   LANES*B_W         lane l bias; 1-cycle latency
//  busy       out  1                 run in progress
//  done       out  1                 all N_OUT results valid
//  ovf        out  1                 sticky accumulator saturation flag for the run
//  read_addr  in   clog2(N_OUT)      result index
//  read_data  out  OUT_W             result at read_addr (combinational)
// BEHAVIOUR
//  Reset: busy=0, done=0, ovf=0, wrom_addr=0, brom_addr=0, state IDLE, all results 0.
//  FSM states: IDLE, MAC, BIAS, STORE, DONE.
//  IDLE/DONE, start=1:
//   - snapshot in_flat into an input register
//   - grp=0, idx=0, clear accumulators
//   - busy=1, done=0, ovf=0, go to MAC
//   - in_flat changes after this edge do not affect the run
//  MAC: N_IN+1 cycles. Cycles 0..N_IN-1 issue wrom_addr for idx. Cycles 1..N_IN add
//   in[idx-1]*w_l into acc_l (all lanes). Products are signed, sign-extended to ACC_W.
//   brom_addr=grp is held for the whole pass.
//  BIAS: 1 cycle; acc_l += sign-extended brom_data lane l.
//  STORE: 1 cycle; writes mem[grp*LANES+l] = act(acc_l).
//   - grp < N_OUT/LANES-1: grp++, idx=0, clear acc, go to MAC
//   - else: busy=0, done=1, go to DONE
//  Latency: done rises exactly (N_OUT/LANES)*(N_IN+3) cycles after the start edge.
//  Accumulation saturates at ACC_W signed limits, never wraps; any clamp sets ovf.
//  act():
//   - sign: acc>0 -> +1, acc<0 -> -1, acc==0 -> 0
//   - ReLU: acc<=0 -> 0, else min(acc, 2^(OUT_W-1)-1)
//   - identity: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//  start while busy: ignored. done holds in DONE until the next start.
//   start held high restarts each time DONE is reached.
//  abort: wins over start in the same cycle, effective from any state.
//   Next edge: IDLE, busy=0, done=0. Results already stored are kept, not valid.
//  read_addr >= N_OUT: read_data=0. Reads are permitted at any time;
//   only reads taken with done=1 are guaranteed complete.
// TESTING
//  Default params, all in=+1, all W=+1, all b=0 -> every read_data=+1; done exactly
//   48*67 cycles after start; ovf=0.
//  Neuron j: W=-1 everywhere, b=+3 -> acc=-61 -> read_data=-1; W=0, b=0 -> 0.
//  ACT_MODE=1, OUT_W=4, LANES=4, N_OUT=8, acc=+20 -> 7; acc=-5 -> 0;
//   done after 2*(N_IN+3) cycles.
//  ACC_W=6, all in=+1, W=+1 -> acc clamps at +31, ovf=1, result +1 (sign).
//  Abort at cycle 100 of run -> busy=0, done=0 next edge; a new start gives correct
//   results; in_flat changed mid-run does not alter results.
//  start pulsed while busy -> ignored, cycle count unchanged. Async reset mid-run ->
//   all outputs 0 immediately.

Source files
------------

// File: rtl/dense_layer_seq.sv
// rtl/dense_layer_seq.sv - sequential fully-connected layer with saturating MAC and result buffer
// Each lane group takes N_IN+1 MAC cycles (1-cycle ROM latency), one bias cycle and one store cycle.
module dense_layer_seq #(
  parameter int N_IN     = 64,
  parameter int N_OUT    = 48,
  parameter int LANES    = 1,
  parameter int IN_W     = 2,
  parameter int W_W      = 2,
  parameter int B_W      = 4,
  parameter int ACC_W    = 12,
  parameter int OUT_W    = 2,
  parameter int ACT_MODE = 0,
  localparam int WA_W    = $clog2(N_IN*N_OUT/LANES),
  localparam int BA_W    = (N_OUT/LANES > 1) ? $clog2(N_OUT/LANES) : 1,
  localparam int RA_W    = $clog2(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_IN*IN_W-1:0]     in_flat,
  output logic [WA_W-1:0]          wrom_addr,
  input  logic [LANES*W_W-1:0]     wrom_data,
  output logic [BA_W-1:0]          brom_addr,
  input  logic [LANES*B_W-1:0]     brom_data,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  input  logic [RA_W-1:0]          read_addr,
  output logic [OUT_W-1:0]         read_data
);

  localparam int CNT_W = $clog2(N_IN+1);
  localparam int II_W  = $clog2(N_IN);
  localparam int P_W   = IN_W + W_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(N_IN-1);
  localparam logic [BA_W-1:0] GRP_LAST = BA_W'(N_OUT/LANES-1);
  localparam logic signed [ACC_W-1:0] O_MAX = ACC_W'((1 <<< (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] O_MIN = ACC_W'(-(1 <<< (OUT_W-1)));

  typedef enum logic [2:0] {IDLE, MAC, BIAS, STORE, DONE} state_t;

  state_t                   state;
  logic [N_IN*IN_W-1:0]     in_reg;
  logic [CNT_W-1:0]         cnt;
  logic [BA_W-1:0]          grp;
  logic signed [ACC_W-1:0]  acc      [LANES];
  logic signed [ACC_W-1:0]  acc_mac  [LANES];
  logic signed [ACC_W-1:0]  acc_bias [LANES];
  logic signed [P_W-1:0]    prod     [LANES];
  logic [LANES-1:0]         clamp_mac;
  logic [LANES-1:0]         clamp_bias;
  logic [II_W-1:0]          x_sel;
  logic signed [IN_W-1:0]   x_cur;
  logic [OUT_W-1:0]         mem [N_OUT];

  // Top bit of the result flags a clamp; overflow shows as disagreeing top two sum bits.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  function automatic logic [OUT_W-1:0] act(input logic signed [ACC_W-1:0] a);
    logic [OUT_W-1:0] r;
    r = '0;
    if (ACT_MODE == 0) begin
      if (a > 0) r = OUT_W'(1);
      else if (a < 0) r = '1;
    end else if (ACT_MODE == 1) begin
      if (a > O_MAX) r = O_MAX[OUT_W-1:0];
      else if (a > 0) r = a[OUT_W-1:0];
    end else begin
      if (a > O_MAX) r = O_MAX[OUT_W-1:0];
      else if (a < O_MIN) r = O_MIN[OUT_W-1:0];
      else r = a[OUT_W-1:0];
    end
    return r;
  endfunction

  // Data arriving in MAC cycle cnt belongs to input index cnt-1.
  assign x_sel = II_W'(cnt - 1'b1);
  assign brom_addr = grp;
  assign read_data = (int'(read_addr) < N_OUT) ? mem[read_addr] : '0;

  always_comb begin
    x_cur = $signed(in_reg[int'(x_sel)*IN_W +: IN_W]);
    clamp_mac = '0;
    clamp_bias = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = x_cur * $signed(wrom_data[l*W_W +: W_W]);
      {clamp_mac[l], acc_mac[l]} = sat_add(acc[l], ACC_W'(prod[l]));
      {clamp_bias[l], acc_bias[l]} = sat_add(acc[l], ACC_W'($signed(brom_data[l*B_W +: B_W])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      wrom_addr <= '0;
      grp       <= '0;
      cnt       <= '0;
      in_reg    <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
      for (int j = 0; j < N_OUT; j++) mem[j] <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          in_reg    <= in_flat;
          grp       <= '0;
          cnt       <= '0;
          wrom_addr <= '0;
          for (int l = 0; l < LANES; l++) acc[l] <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          ovf       <= 1'b0;
          state     <= MAC;
        end
        MAC: begin
          if (cnt != '0) begin
            for (int l = 0; l < LANES; l++) acc[l] <= acc_mac[l];
            if (|clamp_mac) ovf <= 1'b1;
          end
          if (cnt == CNT_LAST) begin
            state <= BIAS;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt < CNT_ADDR_LAST) wrom_addr <= wrom_addr + 1'b1;
          end
        end
        BIAS: begin
          for (int l = 0; l < LANES; l++) acc[l] <= acc_bias[l];
          if (|clamp_bias) ovf <= 1'b1;
          state <= STORE;
        end
        STORE: begin
          for (int l = 0; l < LANES; l++) mem[int'(grp)*LANES + l] <= act(acc[l]);
          if (grp == GRP_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            grp       <= grp + 1'b1;
            cnt       <= '0;
            wrom_addr <= wrom_addr + 1'b1;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            state     <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
